// File: rtl/monitor_uart_tx.sv
`timescale 1ns / 1ps
// monitor_uart_tx
//   Queues 8-bit monitoring samples in a small FIFO and sends each one as a
//   UART 8N1 frame (start, 8 data bits LSB first, stop) on a single pin.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   sample_in     sample captured when sample_strobe is high
//   sample_strobe one-cycle capture pulse
//   tx            serial line, idle high (registered)
//   busy          high while a frame is in progress (registered)
//   fifo_level    number of queued samples (registered)
//   overflow_cnt  dropped-sample count, saturating at 255 (registered)
module monitor_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    sample_in,
    input  logic                          sample_strobe,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    overflow_cnt
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [LvlW-1:0] LvlFull  = LvlW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic [7:0]      ovf_q, ovf_d;

    // Transmitter
    state_e          state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic drop;
    logic baud_done;

    // FIFO control: a pop only happens from IDLE, and a pop on the same edge
    // frees a slot so a strobe into a full FIFO is still accepted.
    always_comb begin
        fifo_full  = (level_q == LvlFull);
        fifo_empty = (level_q == '0);
        pop        = (state_q == StIdle) && !fifo_empty;
        push       = sample_strobe && (!fifo_full || pop);
        drop       = sample_strobe && fifo_full && !pop;

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LvlW'(1);
        end

        ovf_d = ovf_q;
        if (drop && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    // Frame sequencer
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        baud_done = (baud_q == BaudLast);

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StStop: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so tx lines up with it.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    // Storage is not reset: clearing the pointers is enough to discard it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign tx           = tx_q;
    assign busy         = busy_q;
    assign fifo_level   = level_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_monitor_uart_tx.sv
`timescale 1ns / 1ps
// Testbench for monitor_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_monitor_uart_tx;

    localparam int C = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sample_in = 8'h00;
    logic       sample_strobe = 1'b0;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;
    logic [7:0] overflow_cnt;

    monitor_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_strobe(sample_strobe),
        .tx           (tx),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting bytes plus the number of cycles left
    // in the current frame (10 bit periods). A pop is only possible when no
    // frame is running, which gives the single idle cycle between frames.
    byte unsigned m_q[$];
    byte unsigned sb_q[$];
    byte unsigned m_cur = 0;
    int           m_rem = 0;
    int           m_ovf = 0;
    bit           m_pop;
    bit           m_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            sb_q.delete();
            m_rem = 0;
            m_ovf = 0;
            m_cur = 0;
        end else begin
            m_full = (m_q.size() == D);
            m_pop  = (m_rem == 0) && (m_q.size() > 0);
            if (m_pop) begin
                m_cur = m_q.pop_front();
                m_rem = 10 * C;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (sample_strobe) begin
                if (!m_full || m_pop) begin
                    m_q.push_back(sample_in);
                    sb_q.push_back(sample_in);
                end else if (m_ovf < 255) begin
                    m_ovf++;
                end
            end
        end
    end

    function automatic int exp_tx();
        int e;
        int b;
        if (m_rem == 0) return 1;
        e = 10 * C - m_rem;
        b = e / C;
        if (b == 0) return 0;
        if (b <= 8) return int'(m_cur[b-1]);
        return 1;
    endfunction

    // Cycle-level comparison of every output against the model.
    always @(negedge clk) begin
        chk("tx", int'(tx), exp_tx());
        chk("busy", int'(busy), int'(m_rem != 0));
        chk("fifo_level", int'(fifo_level), m_q.size());
        chk("overflow_cnt", int'(overflow_cnt), m_ovf);
    end

    // Frame monitor: decodes the serial line and checks each byte against the
    // scoreboard of accepted samples.
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_byte   = 8'h00;
            end
        end else begin
            mon_cnt++;
            if ((mon_cnt % C == C / 2) && (mon_cnt / C >= 1) && (mon_cnt / C <= 8)) begin
                mon_byte[mon_cnt/C-1] = tx;
            end
            if (mon_cnt == 9 * C + C / 2) begin
                chk("stop bit", int'(tx), 1);
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL frame byte: got 0x%02h, expected no frame", mon_byte);
                end else begin
                    chk("frame byte", int'(mon_byte), int'(sb_q.pop_front()));
                end
                mon_active = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        sample_in     = d;
        sample_strobe = 1'b1;
        step(1);
        sample_strobe = 1'b0;
        sample_in     = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_rem != 0 || m_q.size() != 0 || mon_active) && n < 5000) begin
            step(1);
            n++;
        end
        chk("drain finished", int'(n < 5000), 1);
        step(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int peak;
        int n;

        // Reset state
        rst_n = 1'b0;
        step(2);
        chk("reset tx", int'(tx), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset fifo_level", int'(fifo_level), 0);
        chk("reset overflow_cnt", int'(overflow_cnt), 0);
        rst_n = 1'b1;
        step(2);

        // Single byte
        strobe(8'hA5);
        chk("single level after strobe", int'(fifo_level), 1);
        step(1);
        chk("single tx falls", int'(tx), 0);
        chk("single level after pop", int'(fifo_level), 0);
        drain();

        // Queueing four consecutive bytes
        peak = 0;
        for (int i = 1; i <= 4; i++) begin
            sample_in     = 8'(i);
            sample_strobe = 1'b1;
            step(1);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        sample_strobe = 1'b0;
        chk("queue peak level", peak, 3);
        drain();
        chk("queue overflow_cnt", int'(overflow_cnt), 0);

        // Overflow: six strobes while a frame is in progress
        strobe(8'h10);
        step(3);
        for (int i = 0; i < 6; i++) begin
            sample_in     = 8'(8'h20 + i);
            sample_strobe = 1'b1;
            step(1);
        end
        sample_strobe = 1'b0;
        chk("overflow count", int'(overflow_cnt), 2);
        chk("overflow level", int'(fifo_level), 4);

        // Full FIFO, strobe on the IDLE pop edge
        n = 0;
        while (busy && n < 1000) begin
            step(1);
            n++;
        end
        chk("wait idle with full fifo", int'(n < 1000), 1);
        sample_in     = 8'h77;
        sample_strobe = 1'b1;
        step(1);
        sample_strobe = 1'b0;
        chk("push+pop full level", int'(fifo_level), 4);
        chk("push+pop full overflow", int'(overflow_cnt), 2);
        drain();

        // Empty idle FIFO: strobe, frame starts one cycle later
        strobe(8'h3C);
        chk("empty strobe busy", int'(busy), 0);
        step(1);
        chk("empty strobe frame start", int'(busy), 1);
        drain();

        // Random traffic
        repeat (300) begin
            sample_strobe = ($urandom_range(0, 15) == 0);
            sample_in     = 8'($urandom);
            step(1);
        end
        sample_strobe = 1'b0;
        drain();

        // Reset during DATA bit 3 with two bytes queued
        strobe(8'h5A);
        strobe(8'h11);
        strobe(8'h22);
        step(15);
        chk("pre-reset busy", int'(busy), 1);
        chk("pre-reset level", int'(fifo_level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-frame reset tx", int'(tx), 1);
        chk("mid-frame reset busy", int'(busy), 0);
        chk("mid-frame reset level", int'(fifo_level), 0);
        chk("mid-frame reset overflow", int'(overflow_cnt), 0);
        step(3);
        rst_n = 1'b1;
        step(100);
        chk("post-reset stays idle", int'(busy), 0);
        strobe(8'hC3);
        drain();

        // Saturation: continuous strobes keep the FIFO full for ~300 drops
        sample_strobe = 1'b1;
        repeat (320) begin
            sample_in = 8'($urandom);
            step(1);
        end
        sample_strobe = 1'b0;
        chk("overflow saturates", int'(overflow_cnt), 255);
        drain();
        chk("overflow holds", int'(overflow_cnt), 255);

        chk("scoreboard empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
